// File: rtl/nvdla_scan_pipe_reg.sv
// Scan-testable DEPTH x WIDTH valid/ready pipeline register on one serial scan chain.
// Optional per-stage parity is compiled in with `define NVDLA_SCAN_PIPE_PARITY_EN.
module nvdla_scan_pipe_reg #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             out_par_err
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] tail;
  logic             in_acc;

`ifdef NVDLA_SCAN_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  assign tail = par_q;
`else
  always_comb begin
    tail = '0;
    for (int k = 0; k < DEPTH; k++) tail[k] = dat_q[k][WIDTH-1];
  end
`endif

  // A stage may advance if it is empty or everything downstream of it advances,
  // so bubbles collapse instead of stalling upstream words.
  always_comb begin
    logic carry;
    en    = '0;
    carry = ~vld_q[DEPTH-1] | out_rdy;
    en[DEPTH-1] = carry;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      carry = ~vld_q[k] | carry;
      en[k] = carry;
    end
  end

  assign in_rdy = en[0] & ~scan_en & ~nvdla_core_rst;
  assign in_acc = in_vld & in_rdy;

  always_comb begin
    int p;
    // NOTE: every always_comb output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    vld_d = vld_q;
    dat_d = dat_q;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
    par_d = par_q;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (scan_en) begin
        // Chain per stage, scan_in side first: vld, dat[0..WIDTH-1], (par).
        vld_d[k]    = (k == 0) ? scan_in : tail[p];
        dat_d[k][0] = vld_q[k];
        for (int i = 1; i < WIDTH; i++) dat_d[k][i] = dat_q[k][i-1];
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
        par_d[k] = dat_q[k][WIDTH-1];
`endif
      end else if (en[k]) begin
        vld_d[k] = (k == 0) ? in_acc : vld_q[p];
        // Data holds on bubbles so idle stages do not toggle.
        if (vld_d[k]) begin
          dat_d[k] = (k == 0) ? in_dat : dat_q[p];
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
          par_d[k] = (k == 0) ? ^in_dat : par_q[p];
`endif
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      vld_q <= '0;
      // NOTE: data flops are reset on purpose: they load RST_VAL, unlike a RAM.
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= RST_VAL;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
      par_q <= {DEPTH{^RST_VAL}};
`endif
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  assign out_vld  = vld_q[DEPTH-1] & ~scan_en;
  assign out_dat  = dat_q[DEPTH-1];
  assign scan_out = tail[DEPTH-1];

`ifdef NVDLA_SCAN_PIPE_PARITY_EN
  assign out_par_err = vld_q[DEPTH-1] & (^dat_q[DEPTH-1] ^ par_q[DEPTH-1]) & ~scan_en;
`else
  assign out_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_scan_pipe_reg.sv
// Bench for nvdla_scan_pipe_reg: directed scenarios plus random traffic against a slot-array
// model with a scoreboard and a bit-vector scan chain.
module tb_nvdla_scan_pipe_reg;
  localparam int W = 8;
  localparam int D = 2;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
  localparam int SB = W + 2;
`else
  localparam int SB = W + 1;
`endif
  localparam int L = D * SB;
  localparam logic [W-1:0] RSTV = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld, in_rdy, out_vld, out_rdy;
  logic [W-1:0] in_dat, out_dat;
  logic         scan_en, scan_in, scan_out, out_par_err;

  always #5 clk = ~clk;

  nvdla_scan_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_dat       (in_dat),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_dat      (out_dat),
    .scan_en      (scan_en),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .out_par_err  (out_par_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: occupancy slots, slot D-1 is the output.
  logic [D-1:0] m_vld;
  logic [W-1:0] m_dat [D];
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
  logic [D-1:0] m_par;
`endif
  logic [W-1:0] sb [$];
  logic [W-1:0] out_log [$];
  bit           sb_on = 1'b0;

  logic         obs_in_rdy, obs_out_vld, obs_scan_out, obs_par_err;
  logic [W-1:0] obs_out_dat;

  function automatic logic [L-1:0] pack_state();
    logic [L-1:0] c;
    c = '0;
    for (int k = 0; k < D; k++) begin
      c[k*SB] = m_vld[k];
      for (int i = 0; i < W; i++) c[k*SB+1+i] = m_dat[k][i];
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
      c[k*SB+W+1] = m_par[k];
`endif
    end
    return c;
  endfunction

  function automatic void unpack_state(input logic [L-1:0] c);
    for (int k = 0; k < D; k++) begin
      m_vld[k] = c[k*SB];
      for (int i = 0; i < W; i++) m_dat[k][i] = c[k*SB+1+i];
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
      m_par[k] = c[k*SB+W+1];
`endif
    end
  endfunction

  function automatic void model_reset();
    m_vld = '0;
    for (int k = 0; k < D; k++) m_dat[k] = RSTV;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
    m_par = {D{^RSTV}};
`endif
    sb.delete();
    sb_on = 1'b1;
  endfunction

  // One clock cycle: drive at negedge, compare outputs, advance the model at the edge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic se, input logic si, input logic r);
    logic [D-1:0] en_m;
    logic [L-1:0] c;
    logic         e_rdy, e_perr, sv;
    logic [W-1:0] sd;
    @(negedge clk);
    in_vld = iv; in_dat = id; out_rdy = ordy; scan_en = se; scan_in = si; rst = r;
    #1;
    // A slot can take a word if the output drains or any slot at or beyond it is empty.
    for (int k = 0; k < D; k++) begin
      en_m[k] = ordy;
      for (int j = k; j < D; j++) if (!m_vld[j]) en_m[k] = 1'b1;
    end
    e_rdy = en_m[0] & !se & !r;
    c = pack_state();
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
    e_perr = m_vld[D-1] & ((^m_dat[D-1]) ^ m_par[D-1]) & !se;
`else
    e_perr = 1'b0;
`endif
    check("in_rdy", 32'(in_rdy), 32'(e_rdy));
    check("out_vld", 32'(out_vld), 32'(m_vld[D-1] & !se));
    check("out_dat", 32'(out_dat), 32'(m_dat[D-1]));
    check("scan_out", 32'(scan_out), 32'(c[L-1]));
    check("out_par_err", 32'(out_par_err), 32'(e_perr));
    obs_in_rdy = in_rdy; obs_out_vld = out_vld; obs_out_dat = out_dat;
    obs_scan_out = scan_out; obs_par_err = out_par_err;

    if (out_vld && ordy) begin
      out_log.push_back(out_dat);
      if (sb_on && !r) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("sb_order", 32'(out_dat), 32'(sb.pop_front()));
      end
    end
    if (iv && e_rdy && sb_on) sb.push_back(id);

    if (r) begin
      model_reset();
    end else if (se) begin
      c = {c[L-2:0], si};
      unpack_state(c);
      sb_on = 1'b0;
      sb.delete();
    end else begin
      for (int k = D - 1; k >= 0; k--) begin
        if (en_m[k]) begin
          if (k == 0) begin
            sv = iv & e_rdy; sd = id;
          end else begin
            sv = m_vld[k-1]; sd = m_dat[k-1];
          end
          m_vld[k] = sv;
          if (sv) begin
            m_dat[k] = sd;
`ifdef NVDLA_SCAN_PIPE_PARITY_EN
            m_par[k] = ^sd;
`endif
          end
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    step(0, '0, 0, 0, 0, 0);
    check({tag, "_out_dat"}, 32'(obs_out_dat), 32'(8'hFF));
    check({tag, "_out_vld"}, 32'(obs_out_vld), 32'd0);
    check({tag, "_in_rdy"}, 32'(obs_in_rdy), 32'd1);
  endtask

  initial begin
    logic [L-1:0] pat, got, prior, exp_prior;
    int           first;
    rst = 1'b1; in_vld = 0; in_dat = '0; out_rdy = 0; scan_en = 0; scan_in = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held: in_rdy low, then reset values once released.
    step(0, '0, 1, 0, 0, 1);
    check("rst_in_rdy", 32'(obs_in_rdy), 32'd0);
    check("rst_out_dat", 32'(obs_out_dat), 32'(8'hFF));
    check_reset_values("rel");

    // Back-to-back stream 01..10 with out_rdy=1.
    out_log.delete();
    first = -1;
    for (int i = 0; i < 19; i++) begin
      if (i < 16) step(1, W'(i + 1), 1, 0, 0, 0);
      else        step(0, '0, 1, 0, 0, 0);
      if (first < 0 && obs_out_vld) first = i;
    end
    // Accepted at the first edge, visible after D-1 more edges, i.e. at observation D.
    check("stream_lat", 32'(first), 32'(D));
    check("stream_cnt", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      check("stream_word", 32'(out_log[i]), 32'(i + 1));

    // Backpressure on a full pipe, then simultaneous in/out.
    step(0, '0, 0, 0, 0, 1);
    out_log.delete();
    step(1, 8'hA1, 0, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0, 0);
    check("bp_rdy", 32'(obs_in_rdy), 32'd0);
    check("bp_hold", 32'(obs_out_dat), 32'(8'hA1));
    step(1, 8'hA3, 0, 0, 0, 0);
    check("bp_hold2", 32'(obs_out_dat), 32'(8'hA1));
    step(1, 8'hA3, 1, 0, 0, 0);
    check("bp_swap_rdy", 32'(obs_in_rdy), 32'd1);
    repeat (3) step(0, '0, 1, 0, 0, 0);
    check("bp_cnt", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      check("bp_w0", 32'(out_log[0]), 32'(8'hA1));
      check("bp_w1", 32'(out_log[1]), 32'(8'hA2));
      check("bp_w2", 32'(out_log[2]), 32'(8'hA3));
    end

    // Scan: shift the pattern in (prior state comes out), then shift it back out.
    step(1, 8'h5C, 0, 0, 0, 0);
    step(1, 8'h3B, 0, 0, 0, 0);
    pat   = L'(20'h2D5A3);
    prior = pack_state();
    for (int i = 0; i < L; i++) begin
      exp_prior[i] = prior[L-1-i];
      step(1, 8'h77, 1, 1, pat[i], 0);
      got[i] = obs_scan_out;
      check("scan_in_rdy", 32'(obs_in_rdy), 32'd0);
      check("scan_out_vld", 32'(obs_out_vld), 32'd0);
    end
    check("scan_prior", 32'(got), 32'(exp_prior));
    for (int i = 0; i < L; i++) begin
      step(0, '0, 0, 1, 1'b0, 0);
      got[i] = obs_scan_out;
    end
    check("scan_replay", 32'(got), 32'(pat));
    // Resume functionally from the shifted-in state.
    for (int i = 0; i < L; i++) step(0, '0, 0, 1, pat[i], 0);
    repeat (4) step(1, 8'h42, 1, 0, 0, 0);

`ifdef NVDLA_SCAN_PIPE_PARITY_EN
    begin
      logic [L-1:0] v;
      int           base;
      base = (D - 1) * SB;
      for (int pv = 1; pv >= 0; pv--) begin
        v = '0;
        v[base] = 1'b1;
        v[base+1] = 1'b1;
        v[base+2] = 1'b1;
        v[base+W+1] = 1'(pv);
        for (int i = 0; i < L; i++) step(0, '0, 0, 1, v[L-1-i], 0);
        step(0, '0, 0, 0, 0, 0);
        check("par_err", 32'(obs_par_err), 32'(pv));
      end
    end
`endif

    // Reset in the middle of a shift and of a stall.
    step(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 1, 1'b1, 0);
    step(0, '0, 0, 1, 1'b1, 1);
    check_reset_values("rst_shift");
    step(1, 8'h11, 0, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0, 1);
    check_reset_values("rst_stall");

    // Random traffic with occasional scan bursts and resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
